// File: rtl/level_meter_pkg.sv
// Shared definitions for the level meter: peak-hold state encoding and the
// result-width rule for the saturating subtractor.
`default_nettype none

package level_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } peak_state_t;

  // A clamped difference can never exceed its minuend, so it needs no extra bit.
  function automatic int sat_sub_width(input int operand_width);
    return operand_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/level_sat_sub.sv
// level_sat_sub: combinational unsigned a - b, clamped at zero instead of wrapping.
// Revision: 1.0
`default_nettype none

module level_sat_sub
  import level_meter_pkg::*;
#(
  parameter int width = 16
) (
  input  logic [width-1:0]                a,
  input  logic [width-1:0]                b,
  output logic [sat_sub_width(width)-1:0] diff
);

  assign diff = (a > b) ? (a - b) : '0;

endmodule

`default_nettype wire

// File: rtl/level_peak_hold.sv
// level_peak_hold: fast-attack/linear-release level plus peak-hold meter, one-entry pipeline.
// Optional sticky overload flag with LEVEL_PEAK_HOLD_OVERLOAD_EN. Revision: 1.0
`default_nettype none

module level_peak_hold
  import level_meter_pkg::*;
#(
  parameter int               width      = 16,
  parameter int               hold_count = 8,
  parameter logic [width-1:0] decay_step = 16'h0100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [width-1:0] i_value,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [width-1:0] o_level,
`ifdef LEVEL_PEAK_HOLD_OVERLOAD_EN
  output logic [width-1:0] o_peak,
  input  logic             i_clear_overload,
  output logic             o_overload
`else
  output logic [width-1:0] o_peak
`endif
);

  localparam int cnt_w = (hold_count < 1) ? 1 : $clog2(hold_count + 1);
  localparam logic [cnt_w-1:0] cnt_load = cnt_w'(hold_count);
  localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(1);

  peak_state_t      state, state_next;
  logic [width-1:0] level, level_next;
  logic [width-1:0] peak, peak_next;
  logic [cnt_w-1:0] count, count_next;
  logic             valid_next;
  logic             accept;
  logic [width-1:0] level_dec;
  logic [width-1:0] peak_dec;

  assign i_ready = !o_valid || o_ready;
  assign accept  = i_valid && i_ready;
  assign o_level = level;
  assign o_peak  = peak;

  level_sat_sub #(.width(width)) u_level_sub (
    .a    (level),
    .b    (decay_step),
    .diff (level_dec)
  );

  level_sat_sub #(.width(width)) u_peak_sub (
    .a    (peak),
    .b    (decay_step),
    .diff (peak_dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      level   <= '0;
      peak    <= '0;
      count   <= '0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_next;
      level   <= level_next;
      peak    <= peak_next;
      count   <= count_next;
      o_valid <= valid_next;
    end
  end

  always_comb begin
    state_next = state;
    level_next = level;
    peak_next  = peak;
    count_next = count;
    valid_next = o_valid;

    if (accept) begin
      valid_next = 1'b1;
    end else if (o_ready) begin
      valid_next = 1'b0;
    end

    if (accept) begin
      level_next = (i_value > level_dec) ? i_value : level_dec;

      // A new or equal non-zero peak always restarts the hold, whatever the state.
      if ((i_value >= peak) && (i_value != '0)) begin
        peak_next  = i_value;
        count_next = cnt_load;
        state_next = HOLD;
      end else begin
        case (state)
          IDLE: begin
            peak_next  = '0;
            count_next = '0;
          end
          HOLD: begin
            if (count <= cnt_one) begin
              count_next = '0;
              state_next = DECAY;
            end else begin
              count_next = count - cnt_one;
            end
          end
          DECAY: begin
            peak_next  = (i_value > peak_dec) ? i_value : peak_dec;
            count_next = '0;
            if (peak_next == '0) begin
              state_next = IDLE;
            end
          end
          default: begin
            state_next = IDLE;
            peak_next  = '0;
            count_next = '0;
          end
        endcase
      end
    end
  end

`ifdef LEVEL_PEAK_HOLD_OVERLOAD_EN
  // Set has priority so a full-scale sample arriving with a clear is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_overload <= 1'b0;
    end else if (accept && (i_value == '1)) begin
      o_overload <= 1'b1;
    end else if (i_clear_overload) begin
      o_overload <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_level_peak_hold.sv
// Directed self-checking bench for level_peak_hold (width 16, hold 3, step 0x1000).
`default_nettype none

module tb_level_peak_hold;
  import level_meter_pkg::*;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] i_value;
  logic        o_valid;
  logic        o_ready;
  logic [15:0] o_level;
  logic [15:0] o_peak;
`ifdef LEVEL_PEAK_HOLD_OVERLOAD_EN
  logic        i_clear_overload;
  logic        o_overload;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  level_peak_hold #(
    .width      (16),
    .hold_count (3),
    .decay_step (16'h1000)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_valid          (i_valid),
    .i_ready          (i_ready),
    .i_value          (i_value),
    .o_valid          (o_valid),
    .o_ready          (o_ready),
    .o_level          (o_level),
`ifdef LEVEL_PEAK_HOLD_OVERLOAD_EN
    .o_peak           (o_peak),
    .i_clear_overload (i_clear_overload),
    .o_overload       (o_overload)
`else
    .o_peak           (o_peak)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one value for exactly one edge; returns #1 after that edge.
  task automatic send(input logic [15:0] x);
    i_valid = 1'b1;
    i_value = x;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] lvl, input logic [15:0] pk);
    check_eq({tag, ".valid"}, 32'(o_valid), 32'd1);
    check_eq({tag, ".level"}, 32'(o_level), 32'(lvl));
    check_eq({tag, ".peak"},  32'(o_peak),  32'(pk));
  endtask

  logic [15:0] lvl_tab [4] = '{16'h3000, 16'h2000, 16'h1000, 16'h1000};
  logic [15:0] pk_tab  [4] = '{16'h4000, 16'h4000, 16'h4000, 16'h3000};

  initial begin
    reset   = 1'b0;
    i_valid = 1'b0;
    i_value = '0;
    o_ready = 1'b1;
`ifdef LEVEL_PEAK_HOLD_OVERLOAD_EN
    i_clear_overload = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.valid",  32'(o_valid), 32'd0);
    check_eq("rst.level",  32'(o_level), 32'd0);
    check_eq("rst.peak",   32'(o_peak),  32'd0);
    check_eq("rst.iready", 32'(i_ready), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // First peak
    send(16'h4000);
    expect_out("first", 16'h4000, 16'h4000);
    check_eq("first.state", 32'(dut.state), 32'(HOLD));

    // Hold for three sections, then linear decay
    for (int k = 0; k < 4; k++) begin
      send(16'h1000);
      expect_out($sformatf("hold%0d", k), lvl_tab[k], pk_tab[k]);
      if (k == 1) check_eq("hold1.state", 32'(dut.state), 32'(HOLD));
      if (k == 2) check_eq("hold2.state", 32'(dut.state), 32'(DECAY));
    end

    // Output retires after an idle cycle with o_ready high
    @(posedge clk);
    #1;
    check_eq("drain.valid", 32'(o_valid), 32'd0);

    // Build DECAY with peak 0x0800, then saturate to zero
    reset = 1'b0;
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    send(16'h0800);
    send(16'h0000);
    send(16'h0000);
    send(16'h0000);
    expect_out("pre_idle", 16'h0000, 16'h0800);
    check_eq("pre_idle.state", 32'(dut.state), 32'(DECAY));
    send(16'h0000);
    expect_out("sat0", 16'h0000, 16'h0000);
    check_eq("sat0.state", 32'(dut.state), 32'(IDLE));
    send(16'h0000);
    expect_out("idle0", 16'h0000, 16'h0000);
    check_eq("idle0.state", 32'(dut.state), 32'(IDLE));

    // Backpressure: result held while o_ready is low
    send(16'h2000);
    expect_out("bp_load", 16'h2000, 16'h2000);
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_value = 16'h5000;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq($sformatf("bp%0d.iready", k), 32'(i_ready), 32'd0);
      expect_out($sformatf("bp%0d", k), 16'h2000, 16'h2000);
      @(posedge clk);
      #1;
    end
    o_ready = 1'b1;
    #1;
    check_eq("bp_release.iready", 32'(i_ready), 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    expect_out("bp_accept", 16'h5000, 16'h5000);

    // Asynchronous reset with a pending output in HOLD
    o_ready = 1'b0;
    #2;
    check_eq("ar_pre.state", 32'(dut.state), 32'(HOLD));
    reset = 1'b0;
    #1;
    check_eq("ar.valid",  32'(o_valid), 32'd0);
    check_eq("ar.level",  32'(o_level), 32'd0);
    check_eq("ar.peak",   32'(o_peak),  32'd0);
    check_eq("ar.iready", 32'(i_ready), 32'd1);
    check_eq("ar.state",  32'(dut.state), 32'(IDLE));
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

`ifdef LEVEL_PEAK_HOLD_OVERLOAD_EN
    check_eq("ovl.reset", 32'(o_overload), 32'd0);
    send(16'hFFFF);
    check_eq("ovl.set", 32'(o_overload), 32'd1);
    i_clear_overload = 1'b1;
    send(16'hFFFF);
    check_eq("ovl.set_wins", 32'(o_overload), 32'd1);
    @(posedge clk);
    #1;
    i_clear_overload = 1'b0;
    check_eq("ovl.clear", 32'(o_overload), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
